// File: rtl/range_prefix_stage.sv
// One MSB-first nibble-compare stage of the range matcher: refines the range-state
// vector, propagates the sticky miss and counts keys first rejected here.
module range_prefix_stage #(
  parameter int unsigned REM_W = 12,
  parameter int unsigned TAG_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [REM_W-1:0]   in_key,
  input  logic [REM_W-1:0]   in_lb,
  input  logic [REM_W-1:0]   in_ub,
  input  logic [3:0]         in_sig,
  input  logic               in_miss,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [REM_W-5:0]   out_key,
  output logic [REM_W-5:0]   out_lb,
  output logic [REM_W-5:0]   out_ub,
  output logic [3:0]         out_sig,
  output logic               out_miss,
  output logic [TAG_W-1:0]   out_tag,
  input  logic               clr_cnt,
  output logic [15:0]        rej_cnt
);

  logic [3:0] a, l, u;
  logic       gt_lb_n, eq_lb_n, lt_ub_n, eq_ub_n;
  logic [3:0] sig_n;
  logic       miss_n;
  logic       accept;

  logic               valid_q, valid_d;
  logic [REM_W-5:0]   key_q, key_d, lb_q, lb_d, ub_q, ub_d;
  logic [3:0]         sig_q, sig_d;
  logic               miss_q, miss_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [15:0]        cnt_q, cnt_d;

  assign a = in_key[REM_W-1 -: 4];
  assign l = in_lb[REM_W-1 -: 4];
  assign u = in_ub[REM_W-1 -: 4];

  // sig layout is {gt_lb, eq_lb, lt_ub, eq_ub}
  always_comb begin
    gt_lb_n = in_sig[3] | (in_sig[2] & (a > l));
    eq_lb_n = in_sig[2] & (a == l);
    lt_ub_n = in_sig[1] | (in_sig[0] & (a < u));
    eq_ub_n = in_sig[0] & (a == u);
    sig_n   = {gt_lb_n, eq_lb_n, lt_ub_n, eq_ub_n};
    miss_n  = in_miss | (~gt_lb_n & ~eq_lb_n) | (~lt_ub_n & ~eq_ub_n);
  end

  assign in_ready = ~flush & (~valid_q | out_ready);
  assign accept   = in_valid & in_ready;

  always_comb begin
    valid_d = valid_q;
    key_d   = key_q;
    lb_d    = lb_q;
    ub_d    = ub_q;
    sig_d   = sig_q;
    miss_d  = miss_q;
    tag_d   = tag_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      key_d   = in_key[REM_W-5:0];
      lb_d    = in_lb[REM_W-5:0];
      ub_d    = in_ub[REM_W-5:0];
      sig_d   = sig_n;
      miss_d  = miss_n;
      tag_d   = in_tag;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Clear has priority; only keys newly rejected in this stage are counted.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (accept && !in_miss && miss_n && (cnt_q != '1)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      key_q   <= '0;
      lb_q    <= '0;
      ub_q    <= '0;
      sig_q   <= '0;
      miss_q  <= 1'b0;
      tag_q   <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      key_q   <= key_d;
      lb_q    <= lb_d;
      ub_q    <= ub_d;
      sig_q   <= sig_d;
      miss_q  <= miss_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = valid_q;
  assign out_key   = key_q;
  assign out_lb    = lb_q;
  assign out_ub    = ub_q;
  assign out_sig   = sig_q;
  assign out_miss  = miss_q;
  assign out_tag   = tag_q;
  assign rej_cnt   = cnt_q;

endmodule

// File: tb/tb_range_prefix_stage.sv
// Directed bench for range_prefix_stage with hand-computed expectations.
module tb_range_prefix_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, in_miss, out_valid, out_ready, out_miss, clr_cnt;
  logic [11:0] in_key, in_lb, in_ub;
  logic [3:0]  in_sig, out_sig;
  logic [7:0]  in_tag, out_tag;
  logic [7:0]  out_key, out_lb, out_ub;
  logic [15:0] rej_cnt;
  logic [15:0] exp_cnt;
  int checks = 0;
  int failures = 0;

  range_prefix_stage #(.REM_W(12), .TAG_W(8)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_key(in_key), .in_lb(in_lb), .in_ub(in_ub), .in_sig(in_sig), .in_miss(in_miss),
    .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready), .out_key(out_key),
    .out_lb(out_lb), .out_ub(out_ub), .out_sig(out_sig), .out_miss(out_miss),
    .out_tag(out_tag), .clr_cnt(clr_cnt), .rej_cnt(rej_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_item(input logic [11:0] k, input logic [11:0] lb, input logic [11:0] ub,
                          input logic [3:0] s, input logic m, input logic [7:0] t);
    in_key = k; in_lb = lb; in_ub = ub; in_sig = s; in_miss = m; in_tag = t;
    in_valid = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_cnt = 1'b0;
    in_key = '0; in_lb = '0; in_ub = '0; in_sig = 4'b0101; in_miss = 1'b0; in_tag = '0;
    exp_cnt = '0;
    #12;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if ({out_key, out_lb, out_ub} !== 24'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", {out_key, out_lb, out_ub}); end
    checks++; if ({out_sig, out_miss, out_tag} !== 13'h0) begin failures++; $display("FAIL reset_sig_tag got=%h exp=0", {out_sig, out_miss, out_tag}); end
    checks++; if (rej_cnt !== 16'h0) begin failures++; $display("FAIL reset_cnt got=%h exp=0", rej_cnt); end
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  task automatic test_compare();
    out_ready = 1'b1;
    set_item(12'h5A3, 12'h500, 12'h5FF, 4'b0101, 1'b0, 8'h11);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL cmp_in_ready got=%b exp=1", in_ready); end
    step();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL cmp1_valid got=%b exp=1", out_valid); end
    checks++; if ({out_key, out_lb, out_ub} !== 24'hA3_00_FF) begin failures++; $display("FAIL cmp1_data got=%h exp=a300ff", {out_key, out_lb, out_ub}); end
    checks++; if ({out_sig, out_miss} !== 5'b0101_0) begin failures++; $display("FAIL cmp1_sig got=%b exp=01010", {out_sig, out_miss}); end
    checks++; if (out_tag !== 8'h11 || rej_cnt !== 16'd0) begin failures++; $display("FAIL cmp1_tag_cnt got=%h/%h exp=11/0", out_tag, rej_cnt); end
    set_item(12'h7A3, 12'h500, 12'h9FF, 4'b0101, 1'b0, 8'h22);
    step();
    checks++; if ({out_sig, out_miss} !== 5'b1010_0) begin failures++; $display("FAIL cmp2_sig got=%b exp=10100", {out_sig, out_miss}); end
    set_item(12'h4A3, 12'h500, 12'h9FF, 4'b0101, 1'b0, 8'h33);
    step();
    checks++; if ({out_sig, out_miss} !== 5'b0010_1) begin failures++; $display("FAIL cmp3_lowmiss got=%b exp=00101", {out_sig, out_miss}); end
    checks++; if (rej_cnt !== 16'd1) begin failures++; $display("FAIL cmp3_cnt got=%0d exp=1", rej_cnt); end
    set_item(12'hA00, 12'h500, 12'h9FF, 4'b0101, 1'b0, 8'h44);
    step();
    checks++; if ({out_sig, out_miss} !== 5'b1000_1) begin failures++; $display("FAIL cmp4_highmiss got=%b exp=10001", {out_sig, out_miss}); end
    checks++; if (rej_cnt !== 16'd2) begin failures++; $display("FAIL cmp4_cnt got=%0d exp=2", rej_cnt); end
    set_item(12'h4A3, 12'h500, 12'h9FF, 4'b0101, 1'b1, 8'h55);
    step();
    checks++; if (out_miss !== 1'b1 || rej_cnt !== 16'd2) begin failures++; $display("FAIL cmp5_sticky got=%b/%0d exp=1/2", out_miss, rej_cnt); end
    set_item(12'h5A3, 12'h500, 12'h5FF, 4'b0101, 1'b1, 8'h66);
    step();
    checks++; if (out_miss !== 1'b1) begin failures++; $display("FAIL cmp6_sticky_inrange got=%b exp=1", out_miss); end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL cmp_drain got=%b exp=0", out_valid); end
    exp_cnt = 16'd2;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    set_item(12'h123, 12'h000, 12'hFFF, 4'b0101, 1'b0, 8'hA1);
    step();
    set_item(12'h456, 12'h000, 12'hFFF, 4'b0101, 1'b0, 8'hB2);
    for (int unsigned i = 0; i < 3; i++) begin
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_stall_ready%0d got=%b exp=0", i, in_ready); end
      checks++; if ({out_valid, out_tag, out_key, out_sig} !== {1'b1, 8'hA1, 8'h23, 4'b1010}) begin
        failures++; $display("FAIL b2b_hold%0d got=%b/%h/%h/%b exp=1/a1/23/1010", i, out_valid, out_tag, out_key, out_sig);
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_release_ready got=%b exp=1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if ({out_valid, out_tag, out_key} !== {1'b1, 8'hB2, 8'h56}) begin
      failures++; $display("FAIL b2b_second got=%b/%h/%h exp=1/b2/56", out_valid, out_tag, out_key);
    end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    set_item(12'h123, 12'h000, 12'hFFF, 4'b0101, 1'b0, 8'hC3);
    step();
    set_item(12'h4A3, 12'h500, 12'h9FF, 4'b0101, 1'b0, 8'hD4);
    flush = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_ready got=%b exp=0", in_ready); end
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
    checks++; if (rej_cnt !== exp_cnt) begin failures++; $display("FAIL flush_cnt got=%0d exp=%0d", rej_cnt, exp_cnt); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_nocapture got=%b exp=0", out_valid); end
  endtask

  task automatic test_saturation();
    out_ready = 1'b1;
    set_item(12'h4A3, 12'h500, 12'h9FF, 4'b0101, 1'b0, 8'hE5);
    while (exp_cnt < 16'hFFFE) begin
      step();
      exp_cnt = exp_cnt + 16'd1;
    end
    checks++; if (rej_cnt !== 16'hFFFE) begin failures++; $display("FAIL sat_pre got=%h exp=fffe", rej_cnt); end
    for (int unsigned i = 0; i < 3; i++) step();
    checks++; if (rej_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_hold got=%h exp=ffff", rej_cnt); end
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0; in_valid = 1'b0;
    checks++; if (rej_cnt !== 16'h0) begin failures++; $display("FAIL sat_clr got=%h exp=0", rej_cnt); end
    set_item(12'hA00, 12'h500, 12'h9FF, 4'b0101, 1'b0, 8'hE6);
    step();
    in_valid = 1'b0;
    checks++; if (rej_cnt !== 16'h1) begin failures++; $display("FAIL sat_restart got=%h exp=1", rej_cnt); end
    step();
  endtask

  task automatic test_reset_stall();
    out_ready = 1'b0;
    set_item(12'h5A3, 12'h500, 12'h5FF, 4'b0101, 1'b0, 8'hF7);
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rst_stall_loaded got=%b exp=1", out_valid); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || rej_cnt !== 16'h0) begin failures++; $display("FAIL rst_async got=%b/%h exp=0/0", out_valid, rej_cnt); end
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    set_item(12'h7A3, 12'h500, 12'h9FF, 4'b0101, 1'b0, 8'h08);
    step();
    in_valid = 1'b0;
    checks++; if ({out_valid, out_tag, out_sig} !== {1'b1, 8'h08, 4'b1010}) begin
      failures++; $display("FAIL rst_first_accept got=%b/%h/%b exp=1/08/1010", out_valid, out_tag, out_sig);
    end
  endtask

  initial begin
    test_reset();
    test_compare();
    test_back_to_back();
    test_flush();
    test_saturation();
    test_reset_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
